// File: rtl/ir_queue_pkg.sv
// lc3b_types: shared LC-3b word, field and opcode types plus the queue entry record.
package lc3b_types;
   typedef logic [15:0] lc3b_word;
   typedef logic [2:0]  lc3b_reg;
   typedef logic [5:0]  lc3b_offset6;
   typedef logic [8:0]  lc3b_offset9;
   typedef enum logic [3:0] {
      op_br, op_add, op_ldb, op_stb, op_jsr, op_and, op_ldr, op_str,
      op_rti, op_not, op_ldi, op_sti, op_jmp, op_shf, op_lea, op_trap
   } lc3b_opcode;
   typedef struct packed {
      lc3b_word pc;
      lc3b_word instr;
   } ir_entry_t;
endpackage

// File: rtl/ir_decode.sv
// ir_decode: combinational split of an LC-3b instruction word into its fields.
module ir_decode
   import lc3b_types::*;
(
   input  lc3b_word    word,
   output lc3b_opcode  opcode,
   output lc3b_reg     dest,
   output lc3b_reg     src1,
   output lc3b_reg     src2,
   output lc3b_offset6 offset6,
   output lc3b_offset9 offset9,
   output logic        a,
   output logic        d
);
   assign opcode  = lc3b_opcode'(word[15:12]);
   assign dest    = word[11:9];
   assign src1    = word[8:6];
   assign src2    = word[2:0];
   assign offset6 = word[5:0];
   assign offset9 = word[8:0];
   assign a       = word[5];
   assign d       = word[4];
endmodule

// File: rtl/ir_queue.sv
// ir_queue: DEPTH-entry FIFO of PC-tagged instructions between fetch and decode,
// with flush on redirect and decoded head fields.
module ir_queue
   import lc3b_types::*;
#(
   parameter int DEPTH  = 4,
   parameter bit BYPASS = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  lc3b_word                   in_instr,
   input  lc3b_word                   in_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output lc3b_word                   out_pc,
   output lc3b_word                   instruction,
   output lc3b_opcode                 opcode,
   output lc3b_reg                    dest,
   output lc3b_reg                    src1,
   output lc3b_reg                    src2,
   output lc3b_offset6                offset6,
   output lc3b_offset9                offset9,
   output logic                       A,
   output logic                       D,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("ir_queue: DEPTH must be a power of two >= 2");
   end
   ir_entry_t mem [DEPTH];
   ir_entry_t head;
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic byp, wr, rd;
   // A bypassed word that decode takes immediately never touches storage.
   always_comb begin
      in_ready    = count != CW'(DEPTH) && !flush;
      byp         = BYPASS && count == '0 && in_valid && !flush;
      out_valid   = count != '0 || byp;
      head        = byp ? {in_pc, in_instr} : mem[rd_ptr];
      wr          = in_valid && in_ready && !(byp && out_ready);
      rd          = count != '0 && out_ready;
      out_pc      = out_valid ? head.pc : '0;
      instruction = out_valid ? head.instr : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) begin
            mem[wr_ptr] <= {in_pc, in_instr};
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (rd) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(wr) - CW'(rd);
      end
   end
   ir_decode u_decode (
      .word    (instruction),
      .opcode  (opcode),
      .dest    (dest),
      .src1    (src1),
      .src2    (src2),
      .offset6 (offset6),
      .offset9 (offset9),
      .a       (A),
      .d       (D)
   );
endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: table vectors, hand sequences and a queue-model random run for
// ir_queue with BYPASS=0 and BYPASS=1.
module tb_ir_queue;
   import lc3b_types::*;
   typedef logic [31:0] q_t[$];
   typedef struct {
      logic v; lc3b_word i; lc3b_word p; logic r; logic f;
      logic ov; lc3b_word oi; lc3b_word opc; logic [2:0] c; logic ir;
   } vec_t;
   logic clk = 1'b0;
   logic rst, flush, in_valid, out_ready;
   lc3b_word in_instr, in_pc;
   logic ir_0, ov_0, a_0, d_0, ir_1, ov_1, a_1, d_1;
   lc3b_word pc_0, ins_0, pc_1, ins_1;
   lc3b_opcode op_0, op_1;
   lc3b_reg dst_0, s1_0, s2_0, dst_1, s1_1, s2_1;
   lc3b_offset6 o6_0, o6_1;
   lc3b_offset9 o9_0, o9_1;
   logic [2:0] cnt_0, cnt_1;
   logic [29:0] fld_0, fld_1;
   int total = 0, bad = 0;
   vec_t tbl[20];
   q_t q0, q1;
   always #5 clk = ~clk;
   ir_queue #(.DEPTH(4), .BYPASS(1'b0)) u0 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_0),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov_0), .out_ready(out_ready),
      .out_pc(pc_0), .instruction(ins_0), .opcode(op_0), .dest(dst_0), .src1(s1_0),
      .src2(s2_0), .offset6(o6_0), .offset9(o9_0), .A(a_0), .D(d_0), .count(cnt_0));
   ir_queue #(.DEPTH(4), .BYPASS(1'b1)) u1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_1),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov_1), .out_ready(out_ready),
      .out_pc(pc_1), .instruction(ins_1), .opcode(op_1), .dest(dst_1), .src1(s1_1),
      .src2(s2_1), .offset6(o6_1), .offset9(o9_1), .A(a_1), .D(d_1), .count(cnt_1));
   assign fld_0 = {op_0, dst_0, s1_0, s2_0, o6_0, o9_0, a_0, d_0};
   assign fld_1 = {op_1, dst_1, s1_1, s2_1, o6_1, o9_1, a_1, d_1};
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", n, act, exp);
      end
   endtask
   function automatic logic [29:0] fexp(input lc3b_word w);
      return {w[15:12], w[11:9], w[8:6], w[2:0], w[5:0], w[8:0], w[5], w[4]};
   endfunction
   function automatic vec_t mk(input logic v, input lc3b_word i, input lc3b_word p,
                               input logic r, input logic f, input logic ov,
                               input lc3b_word oi, input lc3b_word opc,
                               input logic [2:0] c, input logic ir);
      vec_t x;
      x.v = v; x.i = i; x.p = p; x.r = r; x.f = f;
      x.ov = ov; x.oi = oi; x.opc = opc; x.c = c; x.ir = ir;
      return x;
   endfunction
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic model_check(input bit b, input q_t q);
      logic er, eb, ev;
      logic [31:0] e;
      er = q.size() != 4 && !flush;
      eb = b && q.size() == 0 && in_valid && !flush;
      ev = q.size() != 0 || eb;
      e  = !ev ? 32'h0 : eb ? {in_pc, in_instr} : q[0];
      chk($sformatf("rnd%0d out_valid", b), b ? ov_1 : ov_0, ev);
      chk($sformatf("rnd%0d in_ready", b), b ? ir_1 : ir_0, er);
      chk($sformatf("rnd%0d count", b), b ? cnt_1 : cnt_0, q.size());
      chk($sformatf("rnd%0d head", b), b ? {pc_1, ins_1} : {pc_0, ins_0}, e);
      chk($sformatf("rnd%0d fields", b), b ? fld_1 : fld_0, fexp(e[15:0]));
   endtask
   function automatic q_t model_next(input bit b, input q_t q);
      logic er, eb, ev;
      if (rst || flush) return {};
      er = q.size() != 4;
      eb = b && q.size() == 0 && in_valid;
      ev = q.size() != 0 || eb;
      if (ev && out_ready && !eb) void'(q.pop_front());
      if (in_valid && er && !(eb && out_ready)) q.push_back({in_pc, in_instr});
      return q;
   endfunction
   initial begin
      tbl[0]  = mk(1, 16'h21A0, 16'h0100, 0, 0, 0, 16'h0000, 16'h0000, 0, 1);
      tbl[1]  = mk(1, 16'h3B41, 16'h0102, 0, 0, 1, 16'h21A0, 16'h0100, 1, 1);
      tbl[2]  = mk(1, 16'h5CE2, 16'h0104, 0, 0, 1, 16'h21A0, 16'h0100, 2, 1);
      tbl[3]  = mk(1, 16'hE603, 16'h0106, 0, 0, 1, 16'h21A0, 16'h0100, 3, 1);
      tbl[4]  = mk(1, 16'h9FFF, 16'h0108, 0, 0, 1, 16'h21A0, 16'h0100, 4, 0);
      tbl[5]  = mk(1, 16'h9FFF, 16'h0108, 1, 0, 1, 16'h21A0, 16'h0100, 4, 0);
      tbl[6]  = mk(0, 16'h0000, 16'h0000, 1, 0, 1, 16'h3B41, 16'h0102, 3, 1);
      tbl[7]  = mk(0, 16'h0000, 16'h0000, 1, 0, 1, 16'h5CE2, 16'h0104, 2, 1);
      tbl[8]  = mk(0, 16'h0000, 16'h0000, 1, 0, 1, 16'hE603, 16'h0106, 1, 1);
      tbl[9]  = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 1);
      tbl[10] = mk(1, 16'h1111, 16'h0200, 0, 0, 0, 16'h0000, 16'h0000, 0, 1);
      tbl[11] = mk(1, 16'h2222, 16'h0202, 0, 0, 1, 16'h1111, 16'h0200, 1, 1);
      tbl[12] = mk(1, 16'h3333, 16'h0204, 1, 0, 1, 16'h1111, 16'h0200, 2, 1);
      tbl[13] = mk(1, 16'h4444, 16'h0206, 1, 0, 1, 16'h2222, 16'h0202, 2, 1);
      tbl[14] = mk(1, 16'h5555, 16'h0208, 1, 0, 1, 16'h3333, 16'h0204, 2, 1);
      tbl[15] = mk(0, 16'h0000, 16'h0000, 0, 0, 1, 16'h4444, 16'h0206, 2, 1);
      tbl[16] = mk(1, 16'h6666, 16'h020A, 0, 0, 1, 16'h4444, 16'h0206, 2, 1);
      tbl[17] = mk(1, 16'h7777, 16'h020C, 1, 1, 1, 16'h4444, 16'h0206, 3, 0);
      tbl[18] = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 1);
      tbl[19] = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 1);
      rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = '0; in_pc = '0;
      #1;
      cyc();
      cyc();
      rst = 0;
      @(negedge clk);
      chk("rst out_valid", ov_0, 0);
      chk("rst count", cnt_0, 0);
      chk("rst in_ready", ir_0, 1);
      chk("rst instruction", ins_0, 16'h0000);
      chk("rst fields", fld_0, 30'h0);
      cyc();
      in_valid = 1; in_instr = 16'h1283; in_pc = 16'h0040;
      cyc();
      in_valid = 0;
      @(negedge clk);
      chk("add out_valid", ov_0, 1);
      chk("add opcode", op_0, op_add);
      chk("add dest", dst_0, 1);
      chk("add src1", s1_0, 2);
      chk("add src2", s2_0, 3);
      chk("add A", a_0, 0);
      chk("add out_pc", pc_0, 16'h0040);
      out_ready = 1;
      cyc();
      out_ready = 0;
      foreach (tbl[k]) begin
         in_valid = tbl[k].v; in_instr = tbl[k].i; in_pc = tbl[k].p;
         out_ready = tbl[k].r; flush = tbl[k].f;
         @(negedge clk);
         chk($sformatf("vec%0d out_valid", k), ov_0, tbl[k].ov);
         chk($sformatf("vec%0d instruction", k), ins_0, tbl[k].oi);
         chk($sformatf("vec%0d out_pc", k), pc_0, tbl[k].opc);
         chk($sformatf("vec%0d count", k), cnt_0, tbl[k].c);
         chk($sformatf("vec%0d in_ready", k), ir_0, tbl[k].ir);
         chk($sformatf("vec%0d fields", k), fld_0, fexp(tbl[k].oi));
         cyc();
      end
      in_valid = 0; out_ready = 0; flush = 0; rst = 1;
      cyc();
      rst = 0;
      in_valid = 1; in_instr = 16'h6A45; in_pc = 16'h0200; out_ready = 1;
      @(negedge clk);
      chk("byp out_valid", ov_1, 1);
      chk("byp offset6", o6_1, 6'h05);
      chk("byp opcode", op_1, op_ldr);
      chk("byp instruction", ins_1, 16'h6A45);
      chk("byp out_pc", pc_1, 16'h0200);
      chk("byp count", cnt_1, 0);
      chk("nobyp out_valid", ov_0, 0);
      cyc();
      in_valid = 0; out_ready = 0;
      @(negedge clk);
      chk("byp count after", cnt_1, 0);
      chk("byp out_valid after", ov_1, 0);
      chk("nobyp count after", cnt_0, 1);
      rst = 1;
      cyc();
      rst = 0;
      q0 = {}; q1 = {};
      for (int n = 0; n < 400; n++) begin
         rst       = $urandom_range(63) == 0;
         flush     = $urandom_range(15) == 0;
         in_valid  = $urandom_range(3) != 0;
         out_ready = $urandom_range(1) != 0;
         in_instr  = lc3b_word'($urandom);
         in_pc     = lc3b_word'($urandom);
         @(negedge clk);
         model_check(1'b0, q0);
         model_check(1'b1, q1);
         @(posedge clk);
         q0 = model_next(1'b0, q0);
         q1 = model_next(1'b1, q1);
         #1;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
